// File: rtl/ay_bus_pkg.sv
// Shared types and constants for the AY/YM bus-cycle generator.
package ay_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_GAP_A,
    ST_WR,
    ST_RD,
    ST_GAP_D
  } ay_state_t;

  // Request fields held for the data half of an access.
  typedef struct packed {
    logic       wr;
    logic       addr_only;
    logic [7:0] data;
  } ay_req_t;

  localparam logic [4:0] CTRL_PREFIX = 5'b11111;

  // {BDIR, BC} codes driven in each phase.
  localparam logic [1:0] BUS_ADDR = 2'b11;
  localparam logic [1:0] BUS_WR   = 2'b10;
  localparam logic [1:0] BUS_RD   = 2'b01;
  localparam logic [1:0] BUS_IDLE = 2'b00;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ay_phase_counter.sv
// Loadable down-counter timing every bus phase and gap; tc marks the final cycle of a phase.
module ay_phase_counter #(
  parameter int W = 3
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/ay_bus_master.sv
// AY/YM BDIR/BC bus-cycle generator: full access 1+2*PHASE_LEN+2*GAP_LEN clocks, one request at a time (REQ_READY only in IDLE).
// Optional last-address cache under AY_BUS_ADDR_CACHE_EN skips the address phase on a repeated register.
module ay_bus_master
  import ay_bus_pkg::*;
#(
  parameter int PHASE_LEN = 4,
  parameter int GAP_LEN   = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic       REQ_WR,
  input  logic       REQ_ADDR_ONLY,
  input  logic [7:0] REQ_ADDR,
  input  logic [7:0] REQ_DATA,
  output logic       RSP_VALID,
  output logic [7:0] RSP_DATA,
  output logic       BDIR,
  output logic       BC,
  output logic [7:0] DO,
  input  logic [7:0] DI
);

  localparam int CW = $clog2(max_int(PHASE_LEN, GAP_LEN) + 1);
  localparam logic [CW-1:0] PHASE_LD = CW'(PHASE_LEN - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(GAP_LEN - 1);

  ay_state_t     state;
  ay_req_t       req_q;
  logic          xfer;
  logic          cache_hit;
  logic          cnt_load;
  logic          cnt_tc;
  logic [CW-1:0] cnt_ld_val;

  assign REQ_READY = (state == ST_IDLE) && !RESET;
  assign xfer      = REQ_VALID && REQ_READY;

`ifdef AY_BUS_ADDR_CACHE_EN
  logic [7:0] cache_addr;
  logic       cache_vld;

  assign cache_hit = cache_vld && !REQ_ADDR_ONLY && (REQ_ADDR == cache_addr);

  // Every issued address phase reloads the cache; control bytes leave it invalid.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cache_vld  <= 1'b0;
      cache_addr <= 8'h00;
    end else if (xfer && !cache_hit) begin
      cache_addr <= REQ_ADDR;
      cache_vld  <= (REQ_ADDR[7:3] != CTRL_PREFIX);
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  // Reload on every state change; the next state is a gap exactly when leaving an active phase.
  assign cnt_load   = (state == ST_IDLE) ? xfer : cnt_tc;
  assign cnt_ld_val = (state == ST_ADDR || state == ST_WR || state == ST_RD) ? GAP_LD : PHASE_LD;

  ay_phase_counter #(
    .W (CW)
  ) u_phase_counter (
    .CLK      (CLK),
    .RESET    (RESET),
    .load     (cnt_load),
    .load_val (cnt_ld_val),
    .tc       (cnt_tc)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      req_q     <= '0;
      BDIR      <= 1'b0;
      BC        <= 1'b0;
      DO        <= 8'h00;
      RSP_VALID <= 1'b0;
      RSP_DATA  <= 8'h00;
    end else begin
      RSP_VALID <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (xfer) begin
            req_q.wr        <= REQ_WR;
            req_q.addr_only <= REQ_ADDR_ONLY;
            req_q.data      <= REQ_DATA;
            if (cache_hit) begin
              if (REQ_WR) begin
                state       <= ST_WR;
                {BDIR, BC}  <= BUS_WR;
                DO          <= REQ_DATA;
              end else begin
                state       <= ST_RD;
                {BDIR, BC}  <= BUS_RD;
              end
            end else begin
              state      <= ST_ADDR;
              {BDIR, BC} <= BUS_ADDR;
              DO         <= REQ_ADDR;
            end
          end
        end
        ST_ADDR: begin
          if (cnt_tc) begin
            state      <= ST_GAP_A;
            {BDIR, BC} <= BUS_IDLE;
          end
        end
        ST_GAP_A: begin
          if (cnt_tc) begin
            if (req_q.addr_only) begin
              state <= ST_IDLE;
            end else if (req_q.wr) begin
              state      <= ST_WR;
              {BDIR, BC} <= BUS_WR;
              DO         <= req_q.data;
            end else begin
              state      <= ST_RD;
              {BDIR, BC} <= BUS_RD;
            end
          end
        end
        ST_WR: begin
          if (cnt_tc) begin
            state      <= ST_GAP_D;
            {BDIR, BC} <= BUS_IDLE;
          end
        end
        ST_RD: begin
          // Last RD cycle: capture DI and strobe it during the first GAP_D cycle.
          if (cnt_tc) begin
            state      <= ST_GAP_D;
            {BDIR, BC} <= BUS_IDLE;
            RSP_VALID  <= 1'b1;
            RSP_DATA   <= DI;
          end
        end
        ST_GAP_D: begin
          if (cnt_tc) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state      <= ST_IDLE;
          {BDIR, BC} <= BUS_IDLE;
        end
      endcase
    end
  end

endmodule
